// File: rtl/ls_issue_queue.sv
// In-order load/store issue queue: buffers dispatched LW/SW ops, wakes operand 1
// from the CDB and issues the head entry to the LS pipe in program order.
module ls_issue_queue #(
    parameter int DEPTH = 8,
    parameter int PTR_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             disp_valid,
    output logic             disp_ready,
    input  logic [15:0]      disp_pc,
    input  logic [3:0]       disp_opcode,
    input  logic [15:0]      disp_opr1,
    input  logic             disp_opr1_rdy,
    input  logic [4:0]       disp_opr1_tag,
    input  logic [15:0]      disp_opr2,
    input  logic [4:0]       disp_rrf_dest,
    input  logic [1:0]       disp_cz,
    input  logic             disp_cmp,
    input  logic             cdb_valid,
    input  logic [4:0]       cdb_tag,
    input  logic [15:0]      cdb_data,
    input  logic             ls_stall,
    input  logic             flush,
    output logic             iss_valid,
    output logic [15:0]      iss_pc,
    output logic [3:0]       iss_opcode,
    output logic [15:0]      iss_opr1,
    output logic [15:0]      iss_opr2,
    output logic [4:0]       iss_rrf_dest,
    output logic [1:0]       iss_cz,
    output logic             iss_cmp,
    output logic             disp_illegal,
    output logic [PTR_W:0]   count
);

    localparam logic [3:0]     OP_LW = 4'b0100;
    localparam logic [3:0]     OP_SW = 4'b0101;
    localparam logic [PTR_W:0] FULL  = (PTR_W + 1)'(DEPTH);

    typedef struct packed {
        logic [15:0] pc;
        logic [3:0]  opcode;
        logic [15:0] opr1;
        logic        rdy;
        logic [4:0]  tag;
        logic [15:0] opr2;
        logic [4:0]  dest;
        logic [1:0]  cz;
        logic        cmp;
    } entry_t;

    entry_t             ent [DEPTH];
    logic [DEPTH-1:0]   vld;
    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    logic [PTR_W:0]     cnt;

    logic   legal;
    logic   accept;
    logic   illegal_req;
    logic   disp_wake;
    logic   issue;
    entry_t head_ent;
    entry_t new_ent;

    assign disp_ready  = (cnt != FULL);
    assign legal       = (disp_opcode == OP_LW) || (disp_opcode == OP_SW);
    assign accept      = disp_valid && disp_ready && legal && !flush;
    assign illegal_req = disp_valid && disp_ready && !legal && !flush;
    assign disp_wake   = !disp_opr1_rdy && cdb_valid && (cdb_tag == disp_opr1_tag);
    assign head_ent    = ent[head];

    // Readiness is the stored bit, so a wakeup at this edge issues one edge later.
    assign issue = vld[head] && head_ent.rdy && !ls_stall && !flush;

    always_comb begin
        new_ent        = '0;
        new_ent.pc     = disp_pc;
        new_ent.opcode = disp_opcode;
        new_ent.opr1   = disp_wake ? cdb_data : disp_opr1;
        new_ent.rdy    = disp_opr1_rdy || disp_wake;
        new_ent.tag    = disp_opr1_tag;
        new_ent.opr2   = disp_opr2;
        new_ent.dest   = disp_rrf_dest;
        new_ent.cz     = disp_cz;
        new_ent.cmp    = disp_cmp;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent[i] <= '0;
            end
        end else if (flush) begin
            vld <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (accept && (tail == PTR_W'(i))) begin
                    vld[i] <= 1'b1;
                    ent[i] <= new_ent;
                end else if (issue && (head == PTR_W'(i))) begin
                    vld[i] <= 1'b0;
                end else if (vld[i] && !ent[i].rdy && cdb_valid &&
                             (ent[i].tag == cdb_tag)) begin
                    ent[i].opr1 <= cdb_data;
                    ent[i].rdy  <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else if (flush) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else begin
            if (issue) begin
                head <= head + 1'b1;
            end
            if (accept) begin
                tail <= tail + 1'b1;
            end
            unique case ({accept, issue})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            iss_valid    <= 1'b0;
            iss_pc       <= '0;
            iss_opcode   <= '0;
            iss_opr1     <= '0;
            iss_opr2     <= '0;
            iss_rrf_dest <= '0;
            iss_cz       <= '0;
            iss_cmp      <= 1'b0;
            disp_illegal <= 1'b0;
        end else begin
            iss_valid    <= issue;
            disp_illegal <= illegal_req;
            if (issue) begin
                iss_pc       <= head_ent.pc;
                iss_opcode   <= head_ent.opcode;
                iss_opr1     <= head_ent.opr1;
                iss_opr2     <= head_ent.opr2;
                iss_rrf_dest <= head_ent.dest;
                iss_cz       <= head_ent.cz;
                iss_cmp      <= head_ent.cmp;
            end
        end
    end

    assign count = cnt;

endmodule
